// File: rtl/data_out_buffer.sv
// data_out_buffer
// Elastic first-word-fall-through output stage that sits after TOP. It takes
// TOP's byte stream, absorbs consumer back-pressure, drops bytes that arrive
// while it is full, and latches a sticky overflow flag when that happens.
//
// Optional feature macro: DATA_OUT_BUFFER_CHECKSUM_EN
//   defined   -> CSUM_O is a running mod-256 sum of every delivered byte
//   undefined -> no checksum register is built; CSUM_O is tied to 8'h00
//
// P_DELAY only exists for port/parameter compatibility with simulation
// models that add intra-assignment delays. It has no functional effect here.
//
// Occupancy FSM
//   state     | meaning
//   S_RST     | first cycle after reset: not ready, nothing valid
//   S_EMPTY   | count == 0: ready, nothing to present
//   S_PARTIAL | 0 < count < P_DEPTH: ready and presenting the head byte
//   S_FULL    | count == P_DEPTH: presenting the head byte, incoming bytes dropped
module data_out_buffer #(
    parameter int P_DEPTH = 8,
    parameter int P_DELAY = 1
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic [7:0]               DATA_I,
    input  logic                     VALID_I,
    output logic                     READY_O,
    output logic [7:0]               DATA_O,
    output logic                     VALID_O,
    input  logic                     READY_I,
    output logic [$clog2(P_DEPTH):0] LEVEL_O,
    output logic                     OVERFLOW_O,
    output logic [7:0]               CSUM_O
);

    localparam int AW = $clog2(P_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(P_DEPTH);

    // Reject parameterisations the pointer arithmetic cannot support.
    if ((P_DEPTH < 2) || ((P_DEPTH & (P_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("data_out_buffer: P_DEPTH must be a power of two >= 2");
    end
    if (P_DELAY < 0) begin : g_bad_delay
        $error("data_out_buffer: P_DELAY must not be negative");
    end

    typedef enum logic [1:0] {
        S_RST     = 2'd0,
        S_EMPTY   = 2'd1,
        S_PARTIAL = 2'd2,
        S_FULL    = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_nxt;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_nxt;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic            overflow_q;
    logic [7:0]      mem [P_DEPTH];
    logic            push;
    logic            pop;
    logic            drop;

    // Handshake outputs decode from the registered state only, so neither
    // READY_I nor DATA_I has a combinational path to the outputs.
    always_comb begin
        READY_O   = 1'b0;
        VALID_O   = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        drop      = 1'b0;
        count_nxt = count_q;
        state_nxt = state_q;

        case (state_q)
            S_RST: begin
                READY_O = 1'b0;
                VALID_O = 1'b0;
            end
            S_EMPTY: begin
                READY_O = 1'b1;
            end
            S_PARTIAL: begin
                READY_O = 1'b1;
                VALID_O = 1'b1;
            end
            S_FULL: begin
                VALID_O = 1'b1;
            end
            default: begin
                READY_O = 1'b0;
                VALID_O = 1'b0;
            end
        endcase

        push = VALID_I && READY_O;
        pop  = VALID_O && READY_I;
        drop = VALID_I && (state_q == S_FULL);

        if (push && !pop) begin
            count_nxt = count_q + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count_q - CW'(1);
        end

        if (count_nxt == '0) begin
            state_nxt = S_EMPTY;
        end else if (count_nxt == FULL_CNT) begin
            state_nxt = S_FULL;
        end else begin
            state_nxt = S_PARTIAL;
        end
    end

    // State, occupancy, pointers and the sticky overflow flag.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= S_RST;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            count_q <= count_nxt;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage array; contents are not reset, validity comes from the count.
    always_ff @(posedge CLK_I) begin
        if (push && !RST_I) begin
            mem[wr_ptr_q] <= DATA_I;
        end
    end

    // Head byte is masked to zero while empty so DATA_O reads 0 after reset.
    assign DATA_O     = VALID_O ? mem[rd_ptr_q] : 8'h00;
    assign LEVEL_O    = count_q;
    assign OVERFLOW_O = overflow_q;

`ifdef DATA_OUT_BUFFER_CHECKSUM_EN
    logic [7:0] csum_q;

    // Running mod-256 sum of every byte handed to the consumer.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            csum_q <= 8'h00;
        end else if (pop) begin
            csum_q <= csum_q + DATA_O;
        end
    end

    assign CSUM_O = csum_q;
`else
    assign CSUM_O = 8'h00;
`endif

endmodule

// File: tb/tb_data_out_buffer.sv
// tb_data_out_buffer
// Directed scenarios followed by a randomized phase, all checked against a
// queue-based reference model of the buffer's externally visible behaviour.
module tb_data_out_buffer;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       vin = 1'b0;
    logic       rin = 1'b0;
    logic       ready_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic [3:0] level_o;
    logic       overflow_o;
    logic [7:0] csum_o;

    int n_tests = 0;
    int n_fail  = 0;

    byte unsigned q[$];
    bit           m_ovf = 1'b0;
    logic [7:0]   m_csum = 8'h00;
    bit           m_after_rst = 1'b1;

    data_out_buffer #(.P_DEPTH(DEPTH), .P_DELAY(1)) dut (
        .CLK_I     (clk),
        .RST_I     (rst),
        .DATA_I    (din),
        .VALID_I   (vin),
        .READY_O   (ready_o),
        .DATA_O    (data_o),
        .VALID_O   (valid_o),
        .READY_I   (rin),
        .LEVEL_O   (level_o),
        .OVERFLOW_O(overflow_o),
        .CSUM_O    (csum_o)
    );

    always #5 clk = ~clk;

    function automatic bit m_ready();
        return !m_after_rst && (q.size() < DEPTH);
    endfunction

    function automatic logic [7:0] exp_csum();
`ifdef DATA_OUT_BUFFER_CHECKSUM_EN
        return m_csum;
`else
        return 8'h00;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge: the model advances with the same inputs the DUT sees.
    task automatic tick();
        bit push;
        bit pop;
        bit drop;
        if (rst) begin
            @(posedge clk);
            q.delete();
            m_ovf       = 1'b0;
            m_csum      = 8'h00;
            m_after_rst = 1'b1;
        end else begin
            push = vin && m_ready();
            pop  = rin && (q.size() != 0);
            drop = vin && (q.size() == DEPTH);
            @(posedge clk);
            if (pop) begin
                m_csum = m_csum + 8'(q[0]);
                void'(q.pop_front());
            end
            if (push) q.push_back(din);
            if (drop) m_ovf = 1'b1;
            m_after_rst = 1'b0;
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "/level"}, 32'(level_o), 32'(q.size()));
        chk({tag, "/valid"}, 32'(valid_o), 32'(q.size() != 0));
        chk({tag, "/ready"}, 32'(ready_o), 32'(m_ready()));
        chk({tag, "/ovf"},   32'(overflow_o), 32'(m_ovf));
        chk({tag, "/csum"},  32'(csum_o), 32'(exp_csum()));
        if (q.size() != 0) chk({tag, "/data"}, 32'(data_o), 32'(q[0]));
    endtask

    initial begin
        // Reset for two cycles
        rst = 1'b1;
        tick();
        tick();
        check_model("reset");
        chk("reset/data_zero", 32'(data_o), 32'h0);
        chk("reset/ready_low", 32'(ready_o), 32'h0);
        rst = 1'b0;
        tick();
        chk("post_reset/ready", 32'(ready_o), 32'h1);
        check_model("post_reset");

        // Single byte
        vin = 1'b1; din = 8'h01; rin = 1'b1;
        tick();
        vin = 1'b0;
        chk("single/valid", 32'(valid_o), 32'h1);
        chk("single/data", 32'(data_o), 32'h01);
        check_model("single");
        tick();
        chk("single/valid_after_pop", 32'(valid_o), 32'h0);
        chk("single/level_after_pop", 32'(level_o), 32'h0);

        // Fill to full, drop one, drain in order
        rin = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            vin = 1'b1; din = 8'(8'h10 + i);
            tick();
            check_model("fill");
        end
        chk("fill/level8", 32'(level_o), 32'd8);
        chk("fill/ready0", 32'(ready_o), 32'h0);
        din = 8'hFF;
        tick();
        vin = 1'b0;
        chk("drop/ovf", 32'(overflow_o), 32'h1);
        chk("drop/level", 32'(level_o), 32'd8);
        rin = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain/data", 32'(data_o), 32'(8'h10 + i));
            check_model("drain");
            tick();
        end
        chk("drain/empty", 32'(valid_o), 32'h0);
        chk("drain/ovf_sticky", 32'(overflow_o), 32'h1);

        // Wrap-around streaming
        rin = 1'b1;
        for (int i = 0; i < 20; i++) begin
            vin = 1'b1; din = 8'(i);
            tick();
            chk("stream/data", 32'(data_o), 32'(i));
            chk("stream/level", 32'(level_o), 32'd1);
            check_model("stream");
        end
        vin = 1'b0;
        tick();
        check_model("stream_end");

        // Back-pressure hold
        rin = 1'b0; vin = 1'b1; din = 8'hA5;
        tick();
        vin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold/data", 32'(data_o), 32'hA5);
            chk("hold/valid", 32'(valid_o), 32'h1);
            tick();
        end
        rin = 1'b1;
        tick();
        check_model("hold_end");

        // Reset mid-operation with three bytes buffered and overflow set
        rin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vin = 1'b1; din = 8'(8'h30 + i);
            tick();
        end
        chk("midrst/level3", 32'(level_o), 32'd3);
        chk("midrst/ovf_set", 32'(overflow_o), 32'h1);
        rst = 1'b1; vin = 1'b1; din = 8'h55; rin = 1'b1;
        tick();
        rst = 1'b0; vin = 1'b0; rin = 1'b0;
        chk("midrst/level0", 32'(level_o), 32'd0);
        chk("midrst/valid0", 32'(valid_o), 32'h0);
        chk("midrst/ovf0", 32'(overflow_o), 32'h0);
        check_model("midrst");
        tick();
        chk("midrst/ready1", 32'(ready_o), 32'h1);

        // Checksum over F0, 20, 01
        vin = 1'b1; din = 8'hF0; tick();
        din = 8'h20; tick();
        din = 8'h01; tick();
        vin = 1'b0; rin = 1'b1;
        tick(); tick(); tick();
`ifdef DATA_OUT_BUFFER_CHECKSUM_EN
        chk("csum/value", 32'(csum_o), 32'h11);
`else
        chk("csum/value", 32'(csum_o), 32'h00);
`endif
        check_model("csum");

        // Randomized traffic with occasional resets and shifting pressure
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            din = 8'($urandom);
            if (i < 200) begin
                vin = ($urandom_range(0, 3) != 0);
                rin = ($urandom_range(0, 3) == 0);
            end else if (i < 400) begin
                vin = ($urandom_range(0, 3) == 0);
                rin = ($urandom_range(0, 3) != 0);
            end else begin
                vin = $urandom_range(0, 1) == 1;
                rin = $urandom_range(0, 1) == 1;
            end
            tick();
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
